// File: rtl/run_detector_pkg.sv
// Shared encodings and helpers for the run detector.
package run_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN0 = 2'b01,
    ST_RUN1 = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_ANY   = 2'b00,
    MODE_ONES  = 2'b01,
    MODE_ZEROS = 2'b10,
    MODE_OFF   = 2'b11
  } mode_e;

  // True when the detection qualifier allows a run of value val to report.
  function automatic logic mode_permits(input logic [1:0] mode, input logic val);
    logic ok;
    ok = 1'b0;
    case (mode)
      MODE_ANY:   ok = 1'b1;
      MODE_ONES:  ok = val;
      MODE_ZEROS: ok = ~val;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/run_detector_sat_counter.sv
// Saturating up-counter with a "restart at one" load, used for the run length.
module sat_counter #(
  parameter int WIDTH = 2,
  parameter int MAX   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load1,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  localparam logic [WIDTH-1:0] MaxC = WIDTH'(MAX);

  // load1 starts a new run; inc extends it until it pins at MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load1) begin
      count_q <= WIDTH'(1);
    end else if (inc && (count_q != MaxC)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/run_detector.sv
// Detects RUN_LEN consecutive equal accepted samples on w, qualified by mode,
// and counts qualified detections in a wrapping counter.
module run_detector
  import run_detector_pkg::*;
#(
  parameter  int RUN_LEN = 2,
  parameter  int HIT_W   = 8,
  localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic [1:0]       state,
  output logic             run_val,
  output logic [CNT_W-1:0] run_cnt,
  output logic             z,
  output logic [HIT_W-1:0] hit_count
);

  localparam logic [CNT_W-1:0] MaxC    = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] MaxM1C  = CNT_W'(RUN_LEN - 1);
  localparam logic             LenOneC = (RUN_LEN == 1);

  state_e           state_q, state_d;
  logic [HIT_W-1:0] hit_count_q, hit_count_d;
  logic             load1, inc, reaches_max;

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (RUN_LEN)
  ) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .load1 (load1),
    .inc   (inc),
    .count (run_cnt)
  );

  // State and detection counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hit_count_q <= hit_count_d;
    end
  end

  // Next-state: a matching sample extends the run, anything else restarts it.
  always_comb begin
    state_d = state_q;
    load1   = 1'b0;
    inc     = 1'b0;
    if (en) begin
      case (state_q)
        ST_RUN0: begin
          if (w) begin
            load1   = 1'b1;
            state_d = ST_RUN1;
          end else begin
            inc = 1'b1;
          end
        end
        ST_RUN1: begin
          if (!w) begin
            load1   = 1'b1;
            state_d = ST_RUN0;
          end else begin
            inc = 1'b1;
          end
        end
        default: begin
          load1   = 1'b1;
          state_d = w ? ST_RUN1 : ST_RUN0;
        end
      endcase
    end
  end

  // A hit is the edge where the run length first reaches RUN_LEN; the new
  // run value always equals w on an accepted edge. Saturated runs do not
  // re-count because inc at the cap never moves from RUN_LEN-1.
  always_comb begin
    reaches_max = (load1 && LenOneC) || (inc && (run_cnt == MaxM1C));
    hit_count_d = hit_count_q;
    if (clear) begin
      hit_count_d = '0;
    end else if (reaches_max && mode_permits(mode, w)) begin
      hit_count_d = hit_count_q + 1'b1;
    end
  end

  assign state     = state_q;
  assign run_val   = (state_q == ST_RUN1);
  assign z         = (run_cnt == MaxC) && mode_permits(mode, run_val);
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector: RUN_LEN=3/HIT_W=4 main instance plus a
// RUN_LEN=1 instance sharing the same inputs.
module tb_run_detector;

  logic       clk = 1'b0;
  logic       reset, en, w, clear;
  logic [1:0] mode;

  logic [1:0] state_a;
  logic       run_val_a, z_a;
  logic [1:0] run_cnt_a;
  logic [3:0] hit_a;

  logic [1:0] state_b;
  logic       run_val_b, z_b;
  logic [0:0] run_cnt_b;
  logic [3:0] hit_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  run_detector #(.RUN_LEN(3), .HIT_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clear(clear),
    .state(state_a), .run_val(run_val_a), .run_cnt(run_cnt_a), .z(z_a),
    .hit_count(hit_a)
  );

  run_detector #(.RUN_LEN(1), .HIT_W(4)) dut1 (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode), .clear(clear),
    .state(state_b), .run_val(run_val_b), .run_cnt(run_cnt_b), .z(z_b),
    .hit_count(hit_b)
  );

  task automatic tick(input logic wv, input logic env);
    w  = wv;
    en = env;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear = 1'b0;
    mode  = 2'b00;
    tick(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({state_a, run_val_a, run_cnt_a, z_a, hit_a} !== 10'b0) begin
      n_err++;
      $display("FAIL reset: state=%b val=%b cnt=%0d z=%b hit=%0d, want all 0",
               state_a, run_val_a, run_cnt_a, z_a, hit_a);
    end
  endtask

  task automatic test_ones_run();
    int exp_cnt[4] = '{1, 2, 3, 3};
    int exp_z[4]   = '{0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1);
      n_vec++;
      if (run_cnt_a !== 2'(exp_cnt[i]) || z_a !== 1'(exp_z[i])) begin
        n_err++;
        $display("FAIL ones_run[%0d]: cnt=%0d z=%b, want cnt=%0d z=%0d",
                 i, run_cnt_a, z_a, exp_cnt[i], exp_z[i]);
      end
    end
    n_vec++;
    if (hit_a !== 4'd1 || state_a !== 2'b10) begin
      n_err++;
      $display("FAIL ones_run_end: hit=%0d state=%b, want hit=1 state=10", hit_a, state_a);
    end
  endtask

  task automatic test_value_change();
    int wv[6]      = '{0, 0, 1, 0, 0, 0};
    int exp_cnt[6] = '{1, 2, 1, 1, 2, 3};
    int exp_z[6]   = '{0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'(wv[i]), 1'b1);
      n_vec++;
      if (run_cnt_a !== 2'(exp_cnt[i]) || z_a !== 1'(exp_z[i])) begin
        n_err++;
        $display("FAIL value_change[%0d]: cnt=%0d z=%b, want cnt=%0d z=%0d",
                 i, run_cnt_a, z_a, exp_cnt[i], exp_z[i]);
      end
    end
    n_vec++;
    if (hit_a !== 4'd1 || run_val_a !== 1'b0) begin
      n_err++;
      $display("FAIL value_change_end: hit=%0d val=%b, want hit=1 val=0", hit_a, run_val_a);
    end
  endtask

  task automatic test_mode();
    do_reset();
    mode = 2'b01;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    n_vec++;
    if (z_a !== 1'b0 || hit_a !== 4'd0 || run_cnt_a !== 2'd3) begin
      n_err++;
      $display("FAIL mode_ones: z=%b hit=%0d cnt=%0d, want z=0 hit=0 cnt=3", z_a, hit_a, run_cnt_a);
    end
    mode = 2'b10;
    #1;
    n_vec++;
    if (z_a !== 1'b1) begin
      n_err++;
      $display("FAIL mode_switch_z: z=%b, want 1", z_a);
    end
    tick(1'b0, 1'b1);
    n_vec++;
    if (hit_a !== 4'd0 || z_a !== 1'b1) begin
      n_err++;
      $display("FAIL mode_switch_hit: hit=%0d z=%b, want hit=0 z=1", hit_a, z_a);
    end
    mode = 2'b11;
    #1;
    n_vec++;
    if (z_a !== 1'b0) begin
      n_err++;
      $display("FAIL mode_off: z=%b, want 0", z_a);
    end
  endtask

  task automatic test_strobe();
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_vec++;
    if (run_cnt_a !== 2'd1 || state_a !== 2'b10) begin
      n_err++;
      $display("FAIL strobe_idle1: cnt=%0d state=%b, want cnt=1 state=10", run_cnt_a, state_a);
    end
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_vec++;
    if (run_cnt_a !== 2'd2 || state_a !== 2'b10 || z_a !== 1'b0) begin
      n_err++;
      $display("FAIL strobe_idle2: cnt=%0d state=%b z=%b, want cnt=2 state=10 z=0",
               run_cnt_a, state_a, z_a);
    end
    tick(1'b1, 1'b1);
    n_vec++;
    if (run_cnt_a !== 2'd3 || z_a !== 1'b1 || hit_a !== 4'd1) begin
      n_err++;
      $display("FAIL strobe_third: cnt=%0d z=%b hit=%0d, want cnt=3 z=1 hit=1",
               run_cnt_a, z_a, hit_a);
    end
  endtask

  task automatic test_wrap_clear();
    do_reset();
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 3; k++) tick(1'(r % 2), 1'b1);
      if (r == 14) begin
        n_vec++;
        if (hit_a !== 4'd15) begin
          n_err++;
          $display("FAIL wrap_15: hit=%0d, want 15", hit_a);
        end
      end
    end
    n_vec++;
    if (hit_a !== 4'd0) begin
      n_err++;
      $display("FAIL wrap_0: hit=%0d, want 0", hit_a);
    end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    clear = 1'b1;
    tick(1'b0, 1'b1);
    clear = 1'b0;
    n_vec++;
    if (hit_a !== 4'd0 || run_cnt_a !== 2'd3 || z_a !== 1'b1) begin
      n_err++;
      $display("FAIL clear_vs_hit: hit=%0d cnt=%0d z=%b, want hit=0 cnt=3 z=1",
               hit_a, run_cnt_a, z_a);
    end
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b1);
    n_vec++;
    if (hit_a !== 4'd1) begin
      n_err++;
      $display("FAIL after_clear: hit=%0d, want 1", hit_a);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    reset = 1'b1;
    clear = 1'b0;
    tick(1'b1, 1'b1);
    reset = 1'b0;
    n_vec++;
    if (state_a !== 2'b00 || run_cnt_a !== 2'd0 || z_a !== 1'b0 || hit_a !== 4'd0 ||
        run_val_a !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset: state=%b cnt=%0d z=%b hit=%0d val=%b, want all 0",
               state_a, run_cnt_a, z_a, hit_a, run_val_a);
    end
    begin
      int wv[4] = '{1, 0, 1, 1};
      int exp_h[4] = '{1, 2, 3, 3};
      for (int i = 0; i < 4; i++) begin
        tick(1'(wv[i]), 1'b1);
        n_vec++;
        if (z_b !== 1'b1 || hit_b !== 4'(exp_h[i]) || run_val_b !== 1'(wv[i])) begin
          n_err++;
          $display("FAIL len1[%0d]: z=%b hit=%0d val=%b, want z=1 hit=%0d val=%0d",
                   i, z_b, hit_b, run_val_b, exp_h[i], wv[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; w = 1'b0; clear = 1'b0; mode = 2'b00;
    test_reset();
    test_ones_run();
    test_value_change();
    test_mode();
    test_strobe();
    test_wrap_clear();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
